// File: rtl/pio_sw_pkg.sv
// Shared constants for the slide-switch PIO: Avalon bus widths and the register map.
package pio_sw_pkg;

    localparam int unsigned AV_ADDR_W = 2;
    localparam int unsigned AV_DATA_W = 32;

    localparam logic [AV_ADDR_W-1:0] ADDR_DATA    = 2'd0;
    localparam logic [AV_ADDR_W-1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [AV_ADDR_W-1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [AV_ADDR_W-1:0] ADDR_RAW     = 2'd3;

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-FF synchroniser followed by a hold-time debouncer.
module switch_debounce_bit #(
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_sync,
    output logic o_stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    // A new level is accepted only after it has differed from stable for DB_CYCLES edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_sync   = r_sync;
    assign o_stable = r_stable;

endmodule

// File: rtl/pio_switch_debounce_irq.sv
// Avalon-MM slave for the board slide switches: debounced data, edge capture and
// a maskable level interrupt.
module pio_switch_debounce_irq
    import pio_sw_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AV_ADDR_W-1:0] address,
    input  logic                 read,
    input  logic                 write,
    input  logic [AV_DATA_W-1:0] writedata,
    output logic [AV_DATA_W-1:0] readdata,
    output logic                 irq,
    input  logic [WIDTH-1:0]     in_port
);

    logic [WIDTH-1:0]     w_sync;
    logic [WIDTH-1:0]     w_stable;
    logic [WIDTH-1:0]     w_chg;
    logic [WIDTH-1:0]     w_w1c;
    logic                 w_mask_we;
    logic [AV_DATA_W-1:0] w_rd_mux;
    logic                 w_unused_wdata;

    logic [WIDTH-1:0]     r_stable_d;
    logic [WIDTH-1:0]     r_irqmask;
    logic [WIDTH-1:0]     r_edgecap;
    logic                 r_irq;
    logic [AV_DATA_W-1:0] r_readdata;

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
        switch_debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_bit (
            .clk      (clk),
            .reset    (reset),
            .i_raw    (in_port[g]),
            .o_sync   (w_sync[g]),
            .o_stable (w_stable[g])
        );
    end

    assign w_chg          = w_stable ^ r_stable_d;
    assign w_mask_we      = write && (address == ADDR_IRQMASK);
    assign w_w1c          = (write && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;
    assign w_unused_wdata = &{1'b0, writedata};

    // Read mux always sees pre-write register contents.
    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:    w_rd_mux = AV_DATA_W'(w_stable);
            ADDR_IRQMASK: w_rd_mux = AV_DATA_W'(r_irqmask);
            ADDR_EDGECAP: w_rd_mux = AV_DATA_W'(r_edgecap);
            ADDR_RAW:     w_rd_mux = AV_DATA_W'(w_sync);
            default:      w_rd_mux = '0;
        endcase
    end

    // A fresh edge outranks a concurrent W1C on the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable_d <= '0;
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_irq      <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_stable_d <= w_stable;
            r_edgecap  <= (r_edgecap & ~w_w1c) | w_chg;
            r_irq      <= |(r_edgecap & r_irqmask);
            if (w_mask_we) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
            if (read) begin
                r_readdata <= w_rd_mux;
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_pio_switch_debounce_irq.sv
// Bench for pio_switch_debounce_irq: directed scenarios plus random traffic against a window-based model.
module tb_pio_switch_debounce_irq;

    localparam int unsigned W  = 4;
    localparam int unsigned DB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [W-1:0] in_port;

    int n_assert = 0;
    int n_fail   = 0;

    pio_switch_debounce_irq #(
        .WIDTH     (W),
        .DB_CYCLES (DB),
        .CNT_W     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .in_port   (in_port)
    );

    always #5 clk = ~clk;

    // Reference model: stable follows a bit once its synchronised value has been
    // constant over the last DB sampled edges.
    logic [W-1:0] m_meta, m_sync, m_stable, m_stable_d, m_edgecap, m_mask;
    logic         m_irq;
    logic [31:0]  m_rdata;
    logic [W-1:0] m_hist [DB];
    logic [W-1:0] t_w1c, t_edge_n;
    logic         t_hi, t_lo;

    always @(posedge clk) begin
        if (reset) begin
            m_meta = '0; m_sync = '0; m_stable = '0; m_stable_d = '0;
            m_edgecap = '0; m_mask = '0; m_irq = 1'b0; m_rdata = '0;
            for (int i = 0; i < int'(DB); i++) m_hist[i] = '0;
        end else begin
            if (read) begin
                case (address)
                    2'd0: m_rdata = {28'b0, m_stable};
                    2'd1: m_rdata = {28'b0, m_mask};
                    2'd2: m_rdata = {28'b0, m_edgecap};
                    default: m_rdata = {28'b0, m_sync};
                endcase
            end
            t_w1c    = (write && address == 2'd2) ? writedata[W-1:0] : '0;
            t_edge_n = (m_edgecap & ~t_w1c) | (m_stable ^ m_stable_d);
            m_irq    = |(m_edgecap & m_mask);
            m_edgecap = t_edge_n;
            if (write && address == 2'd1) m_mask = writedata[W-1:0];
            for (int i = int'(DB) - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0]  = m_sync;
            m_stable_d = m_stable;
            for (int b = 0; b < int'(W); b++) begin
                t_hi = 1'b1; t_lo = 1'b1;
                for (int k = 0; k < int'(DB); k++) begin
                    t_hi = t_hi & m_hist[k][b];
                    t_lo = t_lo & ~m_hist[k][b];
                end
                if (t_hi) m_stable[b] = 1'b1;
                else if (t_lo) m_stable[b] = 1'b0;
            end
            m_sync = m_meta;
            m_meta = in_port;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled on the falling edge and compared with the model.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        chk("rdata_vs_model", readdata, m_rdata);
        chk("irq_vs_model", {31'b0, irq}, {31'b0, m_irq});
    endtask

    task automatic do_read(input logic [1:0] a);
        address = a; read = 1'b1;
        cyc();
        read = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        cyc();
        write = 1'b0;
    endtask

    initial begin
        bit found;
        int hold;

        reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0; in_port = 4'hF;
        cyc(); cyc();
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0; in_port = 4'h0;
        do_read(2'd0);
        chk("first_read_data", readdata, 32'h0);
        repeat (8) cyc();

        // Clean edge: DATA loads 5 on the 7th edge (stable updates on the 6th).
        in_port = 4'h5;
        for (int k = 1; k <= 10; k++) begin
            address = 2'd0; read = 1'b1;
            cyc();
            chk($sformatf("clean_edge_k%0d", k), readdata, (k >= 7) ? 32'h5 : 32'h0);
        end
        read = 1'b0;
        do_read(2'd2);
        chk("edgecap_after_edge", readdata, 32'h5);
        do_read(2'd3);
        chk("raw_after_edge", readdata, 32'h5);
        do_write(2'd0, 32'hFFFF_FFFF);
        do_read(2'd0);
        chk("data_write_ignored", readdata, 32'h5);

        // Glitch shorter than DB never reaches stable.
        in_port = 4'h0;
        repeat (10) cyc();
        do_write(2'd2, 32'hF);
        in_port = 4'h1;
        repeat (3) cyc();
        in_port = 4'h0;
        repeat (10) cyc();
        do_read(2'd0);
        chk("glitch_data", readdata, 32'h0);
        do_read(2'd2);
        chk("glitch_edgecap", readdata, 32'h0);

        // IRQ path.
        do_write(2'd1, 32'h1);
        in_port = 4'h1;
        repeat (7) cyc();
        chk("irq_before_set", {31'b0, irq}, 32'h0);
        cyc();
        chk("irq_after_set", {31'b0, irq}, 32'h1);
        do_write(2'd2, 32'h1);
        chk("irq_hold_after_w1c", {31'b0, irq}, 32'h1);
        cyc();
        chk("irq_clear_after_w1c", {31'b0, irq}, 32'h0);
        do_write(2'd1, 32'h0);
        in_port = 4'h0;
        repeat (10) cyc();
        chk("irq_masked", {31'b0, irq}, 32'h0);
        do_read(2'd2);
        chk("edgecap_masked_set", readdata, 32'h1);
        do_write(2'd2, 32'hF);

        // Read and write to IRQMASK in the same cycle returns the old value.
        address = 2'd1; writedata = 32'hA; write = 1'b1; read = 1'b1;
        cyc();
        write = 1'b0; read = 1'b0;
        chk("rw_same_cycle_old", readdata, 32'h0);
        do_read(2'd1);
        chk("irqmask_readback", readdata, 32'hA);
        do_write(2'd1, 32'h0);

        // W1C on bit2 exactly while its change pulse is live.
        in_port = 4'h4;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if ((m_stable[2] ^ m_stable_d[2]) == 1'b1) found = 1'b1;
            else cyc();
        end
        chk("collision_found", {31'b0, found}, 32'h1);
        do_write(2'd2, 32'h4);
        do_read(2'd2);
        chk("collision_set_wins", readdata, 32'h4);
        do_write(2'd2, 32'hF);

        // Reset in the middle of a debounce count.
        in_port = 4'h8;
        repeat (4) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        do_read(2'd0);
        chk("mid_reset_data", readdata, 32'h0);
        repeat (5) cyc();
        do_read(2'd0);
        chk("mid_reset_reaccept", readdata, 32'h8);

        // Random traffic.
        hold = 0;
        for (int n = 0; n < 600; n++) begin
            if (hold == 0) begin
                in_port = W'($urandom);
                hold = int'($urandom_range(1, 8));
            end
            hold--;
            address   = 2'($urandom);
            read      = 1'($urandom);
            write     = ($urandom_range(0, 3) == 0);
            writedata = $urandom;
            cyc();
        end
        read = 1'b0; write = 1'b0;
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
